bcd_up_accumulator: RTL and testbench

- Multi-digit BCD up-counter/accumulator for the score path: adds a BCD operand to the running count, one digit per clock, LSD first, with ripple carry.
- Counterpart of the single-digit BCD down counter used for timers: counts up, multi-digit, operand-driven.
- Supports synchronous load, synchronous clear, a valid/ready request handshake, a done pulse, a sticky overflow flag and a combinational terminal-count output.
- Sits between game-event logic (issues add requests) and the score display digits.

---
 rtl/bcd_up_accumulator.sv | 139 +++++++++++++
 tb/tb_bcd_up_accumulator.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_up_accumulator.sv
// Multi-digit BCD up-accumulator: adds a BCD operand to the count one digit per clock, LSD first.
// Define BCD_ACC_SATURATE_EN to saturate the count at all 9s on MSD carry-out instead of wrapping.
module bcd_up_accumulator #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  loadN,
  input  logic                  reset_counter,
  input  logic [4*DIGITS-1:0]   datain,
  input  logic                  add_valid,
  input  logic [4*DIGITS-1:0]   add_value,
  output logic                  add_ready,
  output logic                  add_done,
  output logic [4*DIGITS-1:0]   count,
  output logic                  overflow,
  output logic                  tc
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [W-1:0]     ALL_NINES = {DIGITS{4'h9}};
`ifdef BCD_ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             done_q;
  logic             overflow_q;
  logic [W-1:0]     count_q;
  logic [W-1:0]     op_q;
  logic [4:0]       dsum;
  logic [W-1:0]     count_nxt;
  logic             at_msd;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [W-1:0] clamp_operand(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = clamp_digit(v[4*i +: 4]);
    return r;
  endfunction

  // Returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    return (s > 5'd9) ? {1'b1, 4'(s - 5'd10)} : {1'b0, s[3:0]};
  endfunction

  function automatic logic [W-1:0] saturate_count(input logic [W-1:0] c, input logic cout);
    return (SAT_EN && cout) ? ALL_NINES : c;
  endfunction

  // Digit datapath: current digit plus operand digit plus ripple carry
  always_comb begin
    dsum      = bcd_digit_add(count_q[4*int'(idx_q) +: 4], op_q[4*int'(idx_q) +: 4], carry_q);
    at_msd    = (idx_q == LAST_IDX);
    count_nxt = count_q;
    count_nxt[4*int'(idx_q) +: 4] = dsum[3:0];
    if (at_msd) count_nxt = saturate_count(count_nxt, dsum[4]);
  end

  always_ff @(posedge clk) begin
    if (add_ready && add_valid) op_q <= clamp_operand(add_value);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else if (!loadN) begin
      count_q <= datain;
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (reset_counter) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (add_valid) begin
            carry_q <= 1'b0;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          count_q <= count_nxt;
          carry_q <= dsum[4];
          if (at_msd) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (dsum[4]) overflow_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign add_ready = (state_q == IDLE);
  assign add_done  = done_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tc        = (count_q == ALL_NINES);

endmodule

// File: tb/tb_bcd_up_accumulator.sv
// Scoreboard bench for bcd_up_accumulator (DIGITS=4): decimal reference model, monitor pops on add_done.
module tb_bcd_up_accumulator;

  localparam int D   = 4;
  localparam int POW = 10000;
`ifdef BCD_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        loadN = 1'b1;
  logic        reset_counter = 1'b0;
  logic        add_valid = 1'b0;
  logic [15:0] datain = '0;
  logic [15:0] add_value = '0;
  logic        add_ready, add_done, overflow, tc;
  logic [15:0] count;

  bcd_up_accumulator #(.DIGITS(D)) dut (
    .clk(clk), .resetN(resetN), .loadN(loadN), .reset_counter(reset_counter),
    .datain(datain), .add_valid(add_valid), .add_value(add_value),
    .add_ready(add_ready), .add_done(add_done), .count(count),
    .overflow(overflow), .tc(tc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   model_count = 0;
  bit   model_ovf = 1'b0;
  bit   ovf_before = 1'b0;

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int m = 1;
    for (int i = 0; i < D; i++) begin
      r += int'(v[4*i +: 4]) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every add_done pops one expected result
  always @(negedge clk) begin
    if (resetN && add_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got add_done=1, expected 0 with no add pending (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_count", 32'(count), 32'(e.cnt));
        check("done_overflow", 32'(overflow), 32'(e.ovf));
        check("done_tc", 32'(tc), 32'(e.cnt == 16'h9999));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!add_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(add_ready), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    loadN = 1'b0;
    datain = v;
    @(negedge clk);
    loadN = 1'b1;
    model_count = bcd2int(v);
    check("load_count", 32'(count), 32'(v));
    check("load_tc", 32'(tc), 32'(v == 16'h9999));
  endtask

  task automatic do_clear();
    @(negedge clk);
    reset_counter = 1'b1;
    @(negedge clk);
    reset_counter = 1'b0;
    model_count = 0;
    model_ovf = 1'b0;
    check("clear_count", 32'(count), 32'd0);
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_tc", 32'(tc), 32'd0);
  endtask

  // Issue one add; returns just after the accepting edge
  task automatic do_add(input logic [15:0] v, input bit hold);
    int n = 0;
    int op = 0;
    int m = 1;
    int sum;
    int d;
    exp_t x;
    @(negedge clk);
    add_valid = 1'b1;
    add_value = v;
    while (!add_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!add_ready) begin
      check("accept_timeout", 32'(add_ready), 32'd1);
      add_valid = 1'b0;
      return;
    end
    for (int i = 0; i < D; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      op += d * m;
      m *= 10;
    end
    ovf_before = model_ovf;
    sum = model_count + op;
    if (sum >= POW) begin
      model_ovf = 1'b1;
      model_count = SAT ? POW - 1 : sum - POW;
    end else begin
      model_count = sum;
    end
    @(posedge clk);
    #1;
    x.cnt = int2bcd(model_count);
    x.ovf = model_ovf;
    x.cyc = cyc + D;
    sb.push_back(x);
    if (!hold) add_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] seq [4];
    int d0;
    int n;

    // Power-on reset
    #2 resetN = 1'b0;
    #1;
    check("por_count", 32'(count), 32'd0);
    check("por_overflow", 32'(overflow), 32'd0);
    check("por_ready", 32'(add_ready), 32'd1);
    check("por_done", 32'(add_done), 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // 0199 + 0001 with digit-by-digit progress
    wait_idle();
    do_load(16'h0199);
    do_add(16'h0001, 1'b0);
    seq[0] = 16'h0190; seq[1] = 16'h0100; seq[2] = 16'h0200; seq[3] = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("ripple_count", 32'(count), 32'(seq[k]));
    end
    wait_idle();
    check("s2_tc", 32'(tc), 32'd0);

    // 9995 + 0010 overflows MSD
    do_load(16'h9995);
    do_add(16'h0010, 1'b0);
    wait_idle();
    check("s3_overflow", 32'(overflow), 32'd1);

    // Asynchronous reset in the middle of an add
    do_add(16'h1111, 1'b0);
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_ready", 32'(add_ready), 32'd1);
    check("async_done", 32'(add_done), 32'd0);
    sb.delete();
    model_count = 0;
    model_ovf = 1'b0;
    @(negedge clk);
    resetN = 1'b1;

    // Load aborts an add during its second digit cycle
    wait_idle();
    do_load(16'h0000);
    d0 = done_cnt;
    do_add(16'h0555, 1'b0);
    @(posedge clk);
    @(negedge clk);
    loadN = 1'b0;
    datain = 16'h1234;
    @(negedge clk);
    loadN = 1'b1;
    sb.delete();
    model_count = 1234;
    model_ovf = ovf_before;
    check("abort_count", 32'(count), 32'h1234);
    check("abort_ready", 32'(add_ready), 32'd1);
    check("abort_done", 32'(add_done), 32'd0);
    repeat (6) @(negedge clk);
    check("abort_hold_count", 32'(count), 32'h1234);
    check("abort_no_done", done_cnt - d0, 0);

    // add_valid held high across two adds
    wait_idle();
    do_load(16'h0000);
    d0 = done_cnt;
    do_add(16'h0001, 1'b1);
    do_add(16'h0002, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("held_valid_adds", done_cnt - d0, 2);
    check("held_valid_count", 32'(count), 32'h0003);

    // Operand digit clamp
    do_load(16'h0000);
    do_add(16'h000C, 1'b0);
    wait_idle();

    // tc, clear, and load-over-clear priority
    do_load(16'h9999);
    do_add(16'h0001, 1'b0);
    wait_idle();
    check("s6_overflow", 32'(overflow), 32'd1);
    do_clear();
    do_load(16'h9999);
    do_add(16'h0001, 1'b0);
    wait_idle();
    @(negedge clk);
    loadN = 1'b0;
    reset_counter = 1'b1;
    datain = 16'h0042;
    @(negedge clk);
    loadN = 1'b1;
    reset_counter = 1'b0;
    model_count = 42;
    check("prio_count", 32'(count), 32'h0042);
    check("prio_overflow", 32'(overflow), 32'd1);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 9);
      if (n == 0) begin
        wait_idle();
        do_load(rand_bcd());
      end else if (n == 1) begin
        wait_idle();
        do_clear();
      end else if (n < 6) begin
        do_add(rand_bcd(), 1'b0);
      end else begin
        do_add(16'($urandom_range(0, 65535)), 1'b0);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
